// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 2:1 mux round-robin arbiter.
//   state_t     : arbiter FSM states
//   GRANT_REQ0/1: requester indices as carried on sel / last_grant
//   HOLD_W      : width of the per-grant beat counter (MAX_HOLD up to 255)
package mux_arb_pkg;

  localparam int unsigned HOLD_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam logic GRANT_REQ0 = 1'b0;
  localparam logic GRANT_REQ1 = 1'b1;

  // Grant state that corresponds to a requester index.
  function automatic state_t grant_state(input logic idx);
    return (idx == GRANT_REQ1) ? GRANT1 : GRANT0;
  endfunction

endpackage

// File: rtl/mux2.sv
// 1-bit 2:1 mux cell.
//   a : selected when s = 0
//   b : selected when s = 1
//   s : select
//   y : output
module mux2 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);

  assign y = s ? b : a;

endmodule

// File: rtl/rr_pick.sv
// Two-way round-robin pick (combinational).
//   v0, v1     : requester valids
//   last_grant : index of the requester that finished the previous grant
//   pick       : index to grant (only meaningful when any = 1)
//   any        : at least one requester is valid
module rr_pick (
  input  logic v0,
  input  logic v1,
  input  logic last_grant,
  output logic pick,
  output logic any
);
  import mux_arb_pkg::*;

  always_comb begin
    any  = v0 | v1;
    pick = GRANT_REQ0;
    if (v0 && v1) begin
      // Tie goes to whoever did not hold the previous grant.
      pick = ~last_grant;
    end else if (v1) begin
      pick = GRANT_REQ1;
    end
  end

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter/sequencer for the shared 2:1 mux datapath.
// A grant is locked for one burst, ended by a source last beat or by
// MAX_HOLD transfers, followed by one idle (re-arbitration) cycle.
//   clk, rst                  : clock, asynchronous active-high reset
//   req{0,1}_valid/data/last  : requester beats
//   req{0,1}_ready            : beat accepted this cycle (combinational)
//   out_valid/data/last       : muxed output beat (combinational)
//   out_ready                 : downstream accepts beat
//   sel                       : registered mux select (0 = req0, 1 = req1)
//   busy                      : a grant is active
// MAX_HOLD legal range is 1..255.
module mux2_arbiter #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             sel,
  output logic             busy
);
  import mux_arb_pkg::*;

  state_t              state_q, state_d;
  logic                sel_q, sel_d;
  logic                last_grant_q, last_grant_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;

  logic                pick;
  logic                any_valid;
  logic                at_limit;
  logic                grant_idx;
  logic                gnt_valid;
  logic                gnt_last;
  logic                xfer;
  logic [WIDTH-1:0]    mux_data;

  // Arbitration between the two requesters.
  rr_pick u_pick (
    .v0         (req0_valid),
    .v1         (req1_valid),
    .last_grant (last_grant_q),
    .pick       (pick),
    .any        (any_valid)
  );

  // Per-bit data steering driven by the registered select.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_mux
    mux2 u_mux2 (
      .a (req0_data[i]),
      .b (req1_data[i]),
      .s (sel_q),
      .y (mux_data[i])
    );
  end

  assign out_data = mux_data;
  assign sel      = sel_q;
  assign busy     = (state_q != IDLE);
  assign at_limit = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= GRANT_REQ0;
      last_grant_q <= GRANT_REQ1;
      hold_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  // Next-state, hold counter and handshake outputs.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    hold_cnt_d   = hold_cnt_q;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    grant_idx    = GRANT_REQ0;
    gnt_valid    = 1'b0;
    gnt_last     = 1'b0;
    xfer         = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d = grant_state(pick);
          sel_d   = pick;
        end
      end

      GRANT0, GRANT1: begin
        grant_idx  = (state_q == GRANT1) ? GRANT_REQ1 : GRANT_REQ0;
        gnt_valid  = grant_idx ? req1_valid : req0_valid;
        gnt_last   = grant_idx ? req1_last  : req0_last;
        out_valid  = gnt_valid;
        out_last   = gnt_last | at_limit;
        req0_ready = out_ready & (grant_idx == GRANT_REQ0);
        req1_ready = out_ready & (grant_idx == GRANT_REQ1);
        xfer       = gnt_valid & out_ready;

        // Stalls (no valid or no ready) leave state and counter untouched.
        if (xfer) begin
          if (gnt_last | at_limit) begin
            state_d      = IDLE;
            last_grant_d = grant_idx;
            hold_cnt_d   = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mux2_arbiter.sv
module tb_mux2_arbiter;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned MAX_HOLD = 4;

  logic             clk;
  logic             rst;
  logic             req0_valid, req0_last, req0_ready;
  logic [WIDTH-1:0] req0_data;
  logic             req1_valid, req1_last, req1_ready;
  logic [WIDTH-1:0] req1_data;
  logic             out_valid, out_last, out_ready;
  logic [WIDTH-1:0] out_data;
  logic             sel, busy;

  // Second instance for the single-beat hold limit.
  logic             h1_req0_ready, h1_req1_ready, h1_out_valid, h1_out_last;
  logic [WIDTH-1:0] h1_out_data;
  logic             h1_sel, h1_busy;

  int checks = 0;
  int passes = 0;

  mux2_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .sel(sel), .busy(busy)
  );

  mux2_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(1)) dut_h1 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(h1_req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(h1_req1_ready),
    .out_valid(h1_out_valid), .out_data(h1_out_data), .out_last(h1_out_last), .out_ready(out_ready),
    .sel(h1_sel), .busy(h1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_data = '0; req0_last = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0;
    out_ready  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b exp 0", busy); else passes++;
    checks++; if (sel !== 1'b0) $display("FAIL reset_sel got %0b exp 0", sel); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b exp 0", out_valid); else passes++;
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
      $display("FAIL reset_ready got %0b%0b exp 00", req0_ready, req1_ready); else passes++;
    // Get into a req1 grant, then reset in the middle of it.
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b1; req1_data = 8'h77; req1_last = 1'b0;
    tick();
    tick();
    #1;
    checks++; if (busy !== 1'b1 || sel !== 1'b1)
      $display("FAIL pre_reset_grant got busy=%0b sel=%0b exp busy=1 sel=1", busy, sel); else passes++;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL midrun_reset_busy got %0b exp 0", busy); else passes++;
    checks++; if (sel !== 1'b0) $display("FAIL midrun_reset_sel got %0b exp 0", sel); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL midrun_reset_out_valid got %0b exp 0", out_valid); else passes++;
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
      $display("FAIL midrun_reset_ready got %0b%0b exp 00", req0_ready, req1_ready); else passes++;
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      logic [7:0] d;
      logic       eb;
      case (c)
        0, 1:    d = 8'hA1;
        2:       d = 8'hB2;
        default: d = 8'hC3;
      endcase
      req0_valid = (c < 4); req0_data = d; req0_last = (c == 3); out_ready = 1'b1;
      eb = (c >= 1 && c <= 3);
      #1;
      checks++; if (busy !== eb) $display("FAIL single_busy c=%0d got %0b exp %0b", c, busy, eb); else passes++;
      checks++; if (out_valid !== eb) $display("FAIL single_valid c=%0d got %0b exp %0b", c, out_valid, eb); else passes++;
      checks++; if (req0_ready !== eb || req1_ready !== 1'b0)
        $display("FAIL single_ready c=%0d got %0b%0b exp %0b0", c, req0_ready, req1_ready, eb); else passes++;
      if (eb) begin
        checks++; if (out_data !== d) $display("FAIL single_data c=%0d got %h exp %h", c, out_data, d); else passes++;
        checks++; if (out_last !== (c == 3)) $display("FAIL single_last c=%0d got %0b exp %0b", c, out_last, (c == 3)); else passes++;
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_alternation();
    int b0 = 0;
    int b1 = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      int eg;
      case (c)
        1, 2, 7, 8: eg = 1;
        4, 5:       eg = 2;
        default:    eg = 0;
      endcase
      req0_valid = 1'b1; req0_data = 8'h00 + 8'(b0); req0_last = b0[0];
      req1_valid = 1'b1; req1_data = 8'h10 + 8'(b1); req1_last = b1[0];
      out_ready = 1'b1;
      #1;
      checks++; if (busy !== (eg != 0)) $display("FAIL alt_busy c=%0d got %0b exp %0b", c, busy, (eg != 0)); else passes++;
      checks++; if (req0_ready !== (eg == 1) || req1_ready !== (eg == 2))
        $display("FAIL alt_ready c=%0d got %0b%0b exp %0b%0b", c, req0_ready, req1_ready, (eg == 1), (eg == 2)); else passes++;
      if (eg != 0) begin
        checks++; if (sel !== (eg == 2)) $display("FAIL alt_sel c=%0d got %0b exp %0b", c, sel, (eg == 2)); else passes++;
        checks++; if (out_data !== ((eg == 1) ? 8'h00 + 8'(b0) : 8'h10 + 8'(b1)))
          $display("FAIL alt_data c=%0d got %h exp %h", c, out_data, (eg == 1) ? 8'h00 + 8'(b0) : 8'h10 + 8'(b1)); else passes++;
        checks++; if (out_last !== ((eg == 1) ? b0[0] : b1[0]))
          $display("FAIL alt_last c=%0d got %0b exp %0b", c, out_last, (eg == 1) ? b0[0] : b1[0]); else passes++;
      end
      tick();
      if (eg == 1) b0++;
      if (eg == 2) b1++;
    end
    idle_inputs();
  endtask

  task automatic test_hold_limit();
    int   b1 = 1;
    logic sent0 = 1'b0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      int eg;
      int eb;
      case (c)
        1, 2, 3, 4, 8, 9: eg = 2;
        6:                eg = 1;
        default:          eg = 0;
      endcase
      case (c)
        1: eb = 1; 2: eb = 2; 3: eb = 3; 4: eb = 4; 8: eb = 5; default: eb = 6;
      endcase
      req1_valid = 1'b1; req1_data = 8'h20 + 8'(b1); req1_last = 1'b0;
      req0_valid = (c >= 1) && !sent0; req0_data = 8'h0A; req0_last = 1'b1;
      out_ready = 1'b1;
      #1;
      checks++; if (busy !== (eg != 0)) $display("FAIL hold_busy c=%0d got %0b exp %0b", c, busy, (eg != 0)); else passes++;
      if (eg == 2) begin
        checks++; if (out_data !== 8'h20 + 8'(eb)) $display("FAIL hold_data c=%0d got %h exp %h", c, out_data, 8'h20 + 8'(eb)); else passes++;
        checks++; if (out_last !== (c == 4)) $display("FAIL hold_last c=%0d got %0b exp %0b", c, out_last, (c == 4)); else passes++;
      end
      if (eg == 1) begin
        checks++; if (out_data !== 8'h0A || out_last !== 1'b1 || sel !== 1'b0)
          $display("FAIL hold_req0_turn got data=%h last=%0b sel=%0b exp 0a 1 0", out_data, out_last, sel); else passes++;
      end
      tick();
      if (eg == 2) b1++;
      if (eg == 1) sent0 = 1'b1;
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    int b0 = 0;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      logic ordy;
      logic eg;
      int   eb;
      ordy = !(c >= 2 && c <= 4);
      eg   = (c >= 1 && c <= 7);
      case (c)
        1: eb = 0; 6: eb = 2; 7: eb = 3; default: eb = 1;
      endcase
      req0_valid = 1'b1; req0_data = 8'h40 + 8'(b0); req0_last = 1'b0;
      out_ready = ordy;
      #1;
      checks++; if (busy !== eg) $display("FAIL bp_busy c=%0d got %0b exp %0b", c, busy, eg); else passes++;
      checks++; if (req0_ready !== (eg & ordy)) $display("FAIL bp_ready c=%0d got %0b exp %0b", c, req0_ready, eg & ordy); else passes++;
      if (eg) begin
        checks++; if (out_data !== 8'h40 + 8'(eb)) $display("FAIL bp_data c=%0d got %h exp %h", c, out_data, 8'h40 + 8'(eb)); else passes++;
        checks++; if (out_last !== (c == 7)) $display("FAIL bp_last c=%0d got %0b exp %0b", c, out_last, (c == 7)); else passes++;
      end
      tick();
      if (eg && ordy) b0++;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    int b0 = 0;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      req0_valid = 1'b1; req0_data = 8'h50 + 8'(b0); req0_last = (b0 == 3); out_ready = 1'b1;
      #1;
      if (c > 0) begin
        checks++; if (out_data !== 8'h50 + 8'(c - 1) || busy !== 1'b1)
          $display("FAIL rmb_beat c=%0d got data=%h busy=%0b exp %h 1", c, out_data, busy, 8'h50 + 8'(c - 1)); else passes++;
      end
      tick();
      if (c > 0) b0++;
    end
    rst = 1'b1;
    req1_valid = 1'b1; req1_data = 8'h60; req1_last = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || sel !== 1'b0 || out_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0)
      $display("FAIL rmb_reset got busy=%0b sel=%0b valid=%0b rdy=%0b%0b exp all 0",
               busy, sel, out_valid, req0_ready, req1_ready); else passes++;
    @(negedge clk);
    rst = 1'b0;
    b0 = 0;
    req0_data = 8'h50 + 8'(b0); req0_last = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL rmb_idle got %0b exp 0", busy); else passes++;
    tick();
    #1;
    checks++; if (busy !== 1'b1 || sel !== 1'b0 || out_data !== 8'h50 || req0_ready !== 1'b1 || req1_ready !== 1'b0)
      $display("FAIL rmb_regrant got busy=%0b sel=%0b data=%h rdy=%0b%0b exp 1 0 50 10",
               busy, sel, out_data, req0_ready, req1_ready); else passes++;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_max_hold1();
    int b0 = 0;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      logic eg;
      eg = (c == 1 || c == 3 || c == 5);
      req0_valid = 1'b1; req0_data = 8'h90 + 8'(b0); req0_last = 1'b0; out_ready = 1'b1;
      #1;
      checks++; if (h1_busy !== eg) $display("FAIL h1_busy c=%0d got %0b exp %0b", c, h1_busy, eg); else passes++;
      if (eg) begin
        checks++; if (h1_out_last !== 1'b1 || h1_out_data !== 8'h90 + 8'(b0))
          $display("FAIL h1_beat c=%0d got last=%0b data=%h exp 1 %h", c, h1_out_last, h1_out_data, 8'h90 + 8'(b0)); else passes++;
      end
      tick();
      if (eg) b0++;
    end
    idle_inputs();
  endtask

  // Random traffic against a cycle-level behavioural model of the rules.
  task automatic test_random();
    int   owner = -1;
    int   beats = 0;
    int   lastg = 1;
    logic msel = 1'b0;
    int   seq[2];
    logic lst[2];
    logic v[2];
    logic [7:0] d[2];
    seq[0] = 0; seq[1] = 0; lst[0] = 1'b0; lst[1] = 1'b1;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic ordy, ev, el;
      for (int r = 0; r < 2; r++) begin
        v[r] = ($urandom_range(0, 3) != 0);
        d[r] = {1'(r), 7'(seq[r])};
      end
      ordy = ($urandom_range(0, 3) != 0);
      req0_valid = v[0]; req0_data = d[0]; req0_last = lst[0];
      req1_valid = v[1]; req1_data = d[1]; req1_last = lst[1];
      out_ready = ordy;
      ev = (owner >= 0) ? v[owner] : 1'b0;
      el = (owner >= 0) ? (lst[owner] || beats == int'(MAX_HOLD) - 1) : 1'b0;
      #1;
      checks++; if (busy !== (owner >= 0)) $display("FAIL rnd_busy n=%0d got %0b exp %0b", n, busy, (owner >= 0)); else passes++;
      checks++; if (sel !== msel) $display("FAIL rnd_sel n=%0d got %0b exp %0b", n, sel, msel); else passes++;
      checks++; if (out_valid !== ev) $display("FAIL rnd_valid n=%0d got %0b exp %0b", n, out_valid, ev); else passes++;
      checks++; if (req0_ready !== (owner == 0 && ordy) || req1_ready !== (owner == 1 && ordy))
        $display("FAIL rnd_ready n=%0d got %0b%0b exp %0b%0b", n, req0_ready, req1_ready,
                 (owner == 0 && ordy), (owner == 1 && ordy)); else passes++;
      if (ev) begin
        checks++; if (out_data !== d[owner] || out_last !== el)
          $display("FAIL rnd_beat n=%0d got data=%h last=%0b exp %h %0b", n, out_data, out_last, d[owner], el); else passes++;
      end
      if (owner < 0) begin
        if (v[0] && v[1]) owner = 1 - lastg;
        else if (v[0])    owner = 0;
        else if (v[1])    owner = 1;
        if (owner >= 0) msel = 1'(owner);
      end else if (ev && ordy) begin
        seq[owner]++;
        lst[owner] = ($urandom_range(0, 2) == 0);
        if (el) begin
          lastg = owner;
          owner = -1;
          beats = 0;
        end else begin
          beats++;
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_alternation();
    test_hold_limit();
    test_backpressure();
    test_reset_mid_burst();
    test_max_hold1();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
